timer_sequencer: RTL and testbench
==================================

// Module: timer_sequencer
// PURPOSE
//  Control FSM for a cascaded chain of digit down-counters (countdown timer datapath).
//  Loads the chain with its default digits, generates the prescaled decrement tick into
//  the least-significant digit's borrow_dn, and detects when the whole chain reaches zero.
//  Supports start, pause/resume and reload, and raises a sticky timeout flag.
//  Sits between the debounced push-button pulses and the digit-timer chain at top level.
// PARAMETERS
//  TICK_DIV  50_000_000  clk cycles per decrement tick (>=2); sims use 4
//  CNT_W     26          prescaler width; must satisfy 2**CNT_W >= TICK_DIV
//  LOAD_CYC  2           cycles load_o is held high when the chain reloads (>=1)
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  RST           in   1      asynchronous, active-high reset
//  start_i       in   1      1-cycle pulse: start / resume / restart
//  pause_i       in   1      1-cycle pulse: pause while running
//  reload_i      in   1      1-cycle pulse: reload defaults and stop (armed)
//  ones_digit_i  in   4      digit_count of the least-significant digit
//  chain_nb_i    in   1      noborrow_dn of the least-significant digit (1 = upper digits nonzero)
//  load_o        out  1      drives RST of every digit; loads default_num
//  tick_o        out  1      1-cycle pulse to the least-significant digit's borrow_dn
//  top_nb_o      out  1      noborrow_up of the most-significant digit; tied 0 (nothing above)
//  run_o         out  1      1 while in RUN
//  timeout_o     out  1      sticky 1 in DONE
// BEHAVIOUR
//  States: IDLE, LOAD, RUN, PAUSE, DONE. Async reset -> IDLE, prescaler=0, load cnt=0, go=0,
//   all outputs 0.
//  Chain zero: zero = (ones_digit_i==0) && !chain_nb_i; combinational from inputs.
//  Command priority in any state: reload_i > start_i > pause_i; lower ones ignored that cycle.
//  IDLE:  start_i -> LOAD with go=1; reload_i -> LOAD with go=0.
//  LOAD:  load_o=1 for exactly LOAD_CYC cycles; prescaler cleared. Then go=1 -> RUN, go=0 -> IDLE.
//   start_i in LOAD sets go=1; reload_i in LOAD restarts the LOAD_CYC count with go=0.
//   pause_i is ignored in LOAD.
//  RUN:   run_o=1. If zero -> DONE on next edge, no tick that cycle (zero beats tick and pause).
//   Else prescaler counts 0..TICK_DIV-1; tick_o=1 for the single cycle it equals TICK_DIV-1.
//   It wraps to 0 on the following edge, so the tick period is exactly TICK_DIV cycles.
//   pause_i -> PAUSE, prescaler frozen; a tick due that same cycle is still issued.
//   reload_i -> LOAD (go=0). start_i has no effect.
//  PAUSE: tick_o=0, prescaler held. start_i -> RUN, resuming from the held count.
//   reload_i -> LOAD (go=0).
//  DONE:  timeout_o=1, run_o=0, tick_o=0. start_i -> LOAD (go=1, auto-restart).
//   reload_i -> LOAD (go=0). timeout_o clears on entering LOAD.
//  Loaded value 00: first RUN cycle sees zero -> DONE, zero ticks issued.
//  Registered outputs (load_o, tick_o, run_o, timeout_o) change only on clk or RST.
//   top_nb_o is constant 0.
//  RST mid-operation: immediate IDLE. Digits are not reloaded until the next start_i/reload_i.
// TESTING (TICK_DIV=4, LOAD_CYC=2, chain = 2 digits, default 15 -> digits load 1,5)
//  RST pulse then start_i -> load_o high 2 cycles, run_o=1, tick_o every 4th cycle.
//   Digits 15,14,..,00, then timeout_o=1 and no further ticks.
//  Pause after 3 ticks (value 12) for 20 cycles -> no ticks, value holds 12.
//   start_i -> next tick after the remaining prescaler cycles; count continues 11..00.
//  reload_i while RUN at value 07 -> load_o 2 cycles, state IDLE, value 15, run_o=0, no ticks.
//  start_i in DONE -> timeout_o falls with load_o, value 15, countdown restarts.
//  Same-cycle reload_i+start_i in RUN -> LOAD then IDLE (reload wins).
//   Same-cycle pause at terminal zero -> DONE.
//  Assert RST while RUN at value 09 -> all outputs 0 asynchronously (before next edge), state IDLE.

Source files
------------

// File: rtl/timer_sequencer.sv
// Countdown-timer control FSM: reloads the digit chain, issues the prescaled
// decrement tick and flags timeout when the whole chain has counted down to zero.
module timer_sequencer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned LOAD_CYC = 2
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       reload_i,
  input  logic [3:0] ones_digit_i,
  input  logic       chain_nb_i,
  output logic       load_o,
  output logic       tick_o,
  output logic       top_nb_o,
  output logic       run_o,
  output logic       timeout_o
);

  localparam int unsigned LCNT_W = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam logic [CNT_W-1:0]  PRESC_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [LCNT_W-1:0] LOAD_LAST  = LCNT_W'(LOAD_CYC - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;

  state_t             state, state_n;
  logic               go, go_n;
  logic [LCNT_W-1:0]  lcnt, lcnt_n;
  logic [CNT_W-1:0]   presc, presc_n;
  logic               tick_n;
  logic               zero;

  assign zero     = (ones_digit_i == 4'd0) && !chain_nb_i;
  assign top_nb_o = 1'b0;

  // Next-state, prescaler and load-length logic; reload > start > pause.
  always_comb begin
    state_n = state;
    go_n    = go;
    lcnt_n  = lcnt;
    presc_n = presc;
    tick_n  = 1'b0;
    case (state)
      IDLE: begin
        if (reload_i) begin
          state_n = LOAD;
          go_n    = 1'b0;
          lcnt_n  = '0;
        end else if (start_i) begin
          state_n = LOAD;
          go_n    = 1'b1;
          lcnt_n  = '0;
        end
      end
      LOAD: begin
        presc_n = '0;
        if (reload_i) begin
          go_n   = 1'b0;
          lcnt_n = '0;
        end else begin
          if (start_i) go_n = 1'b1;
          if (lcnt == LOAD_LAST) state_n = go_n ? RUN : IDLE;
          else                   lcnt_n  = lcnt + LCNT_W'(1);
        end
      end
      RUN: begin
        if (reload_i) begin
          state_n = LOAD;
          go_n    = 1'b0;
          lcnt_n  = '0;
        end else if (zero) begin
          state_n = DONE;
        end else begin
          // The pause cycle still counts and may still tick.
          tick_n  = (presc == PRESC_LAST);
          presc_n = tick_n ? '0 : presc + CNT_W'(1);
          if (pause_i) state_n = PAUSE;
        end
      end
      PAUSE: begin
        if (reload_i) begin
          state_n = LOAD;
          go_n    = 1'b0;
          lcnt_n  = '0;
        end else if (start_i) begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (reload_i) begin
          state_n = LOAD;
          go_n    = 1'b0;
          lcnt_n  = '0;
        end else if (start_i) begin
          state_n = LOAD;
          go_n    = 1'b1;
          lcnt_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; outputs registered from the next state so they align with it.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      go        <= 1'b0;
      lcnt      <= '0;
      presc     <= '0;
      load_o    <= 1'b0;
      tick_o    <= 1'b0;
      run_o     <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_n;
      go        <= go_n;
      lcnt      <= lcnt_n;
      presc     <= presc_n;
      load_o    <= (state_n == LOAD);
      tick_o    <= tick_n;
      run_o     <= (state_n == RUN);
      timeout_o <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer driving a two-digit chain model (default 15);
// expected digit values are queued when a countdown is launched and popped per tick.
module tb_timer_sequencer;

  localparam int unsigned TD = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned LC = 2;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0, pause = 1'b0, reload = 1'b0;
  logic       load_o, tick_o, top_nb_o, run_o, timeout_o;
  logic [3:0] ones = 4'd0, tens = 4'd0;
  logic       chain_nb;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  timer_sequencer #(.TICK_DIV(TD), .CNT_W(CW), .LOAD_CYC(LC)) dut (
    .clk(clk), .RST(RST), .start_i(start), .pause_i(pause), .reload_i(reload),
    .ones_digit_i(ones), .chain_nb_i(chain_nb), .load_o(load_o), .tick_o(tick_o),
    .top_nb_o(top_nb_o), .run_o(run_o), .timeout_o(timeout_o)
  );

  // Two-digit down-counter chain loaded with 15.
  assign chain_nb = (tens != 4'd0);
  always @(posedge clk) begin
    if (load_o) begin
      ones <= 4'd5;
      tens <= 4'd1;
    end else if (tick_o) begin
      if (ones == 4'd0) begin
        ones <= 4'd9;
        tens <= tens - 4'd1;
      end else begin
        ones <= ones - 4'd1;
      end
    end
  end

  function automatic int value();
    return 10 * int'(tens) + int'(ones);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic s, input logic p, input logic r);
    start = s; pause = p; reload = r;
    step();
    start = 1'b0; pause = 1'b0; reload = 1'b0;
  endtask

  task automatic load_phase(input string tag);
    int n = 0;
    while (load_o === 1'b1 && n < 10) begin
      n++;
      step();
    end
    check({tag, "_load_len"}, 32'(n), 32'(LC));
  endtask

  task automatic push_range(input int hi, input int lo);
    for (int v = hi; v >= lo; v--) exp_q.push_back(v);
  endtask

  // Wait for the next tick, check its spacing, then the digit value it produced.
  task automatic tick(input string tag, input int gap);
    int n = 0;
    while (tick_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_gap"}, 32'(n), 32'(gap));
    step();
    if (exp_q.size() == 0) check({tag, "_sb_underflow"}, 32'(exp_q.size()), 32'd1);
    else                   check({tag, "_value"}, 32'(value()), 32'(exp_q.pop_front()));
  endtask

  task automatic no_ticks(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (tick_o === 1'b1) seen++;
    end
    check({tag, "_no_ticks"}, 32'(seen), 32'd0);
  endtask

  initial begin
    // Reset
    repeat (2) step();
    check("rst_load", 32'(load_o), 32'd0);
    check("rst_run", 32'(run_o), 32'd0);
    check("rst_tick", 32'(tick_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_top_nb", 32'(top_nb_o), 32'd0);
    RST = 1'b0;
    step();

    // Full countdown 15..00 then timeout
    cmd(1'b1, 1'b0, 1'b0);
    check("t1_load_hi", 32'(load_o), 32'd1);
    load_phase("t1");
    check("t1_run", 32'(run_o), 32'd1);
    check("t1_val15", 32'(value()), 32'd15);
    push_range(14, 0);
    tick("t1_first", TD);
    repeat (14) tick("t1", TD - 1);
    step();
    check("t1_timeout", 32'(timeout_o), 32'd1);
    check("t1_run_off", 32'(run_o), 32'd0);
    no_ticks("t1_done", 10);
    check("t1_timeout_sticky", 32'(timeout_o), 32'd1);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Restart from DONE, pause at 12, resume, reload at 07
    cmd(1'b1, 1'b0, 1'b0);
    check("t2_timeout_fall", 32'(timeout_o), 32'd0);
    check("t2_load_hi", 32'(load_o), 32'd1);
    load_phase("t2");
    check("t2_val15", 32'(value()), 32'd15);
    push_range(14, 12);
    tick("t2_first", TD);
    repeat (2) tick("t2", TD - 1);
    cmd(1'b0, 1'b1, 1'b0);
    check("t2_paused_run", 32'(run_o), 32'd0);
    no_ticks("t2_pause", 20);
    check("t2_pause_val", 32'(value()), 32'd12);
    cmd(1'b1, 1'b0, 1'b0);
    check("t2_resume_run", 32'(run_o), 32'd1);
    push_range(11, 7);
    // Prescaler stood at 2 when frozen (one cycle after the wrap plus the pause cycle).
    tick("t2_resume", TD - 2);
    repeat (4) tick("t2", TD - 1);
    cmd(1'b0, 1'b0, 1'b1);
    check("t2_reload_run", 32'(run_o), 32'd0);
    check("t2_reload_load", 32'(load_o), 32'd1);
    load_phase("t2_reload");
    check("t2_idle_run", 32'(run_o), 32'd0);
    check("t2_idle_load", 32'(load_o), 32'd0);
    check("t2_idle_val", 32'(value()), 32'd15);
    no_ticks("t2_idle", 12);
    check("t2_idle_run2", 32'(run_o), 32'd0);

    // Same-cycle reload+start in RUN: reload wins
    cmd(1'b1, 1'b0, 1'b0);
    load_phase("t3");
    push_range(14, 14);
    tick("t3_first", TD);
    cmd(1'b1, 1'b0, 1'b1);
    check("t3_load_hi", 32'(load_o), 32'd1);
    check("t3_run_off", 32'(run_o), 32'd0);
    load_phase("t3_reload");
    check("t3_idle_run", 32'(run_o), 32'd0);
    check("t3_idle_val", 32'(value()), 32'd15);
    no_ticks("t3_idle", 8);

    // Pause in the same cycle the chain reads zero: DONE wins
    cmd(1'b1, 1'b0, 1'b0);
    load_phase("t4");
    push_range(14, 0);
    tick("t4_first", TD);
    repeat (14) tick("t4", TD - 1);
    cmd(1'b0, 1'b1, 1'b0);
    check("t4_timeout", 32'(timeout_o), 32'd1);
    check("t4_run_off", 32'(run_o), 32'd0);
    no_ticks("t4_done", 5);

    // Asynchronous reset while running at 09
    cmd(1'b1, 1'b0, 1'b0);
    check("t5_timeout_fall", 32'(timeout_o), 32'd0);
    load_phase("t5");
    push_range(14, 9);
    tick("t5_first", TD);
    repeat (5) tick("t5", TD - 1);
    check("t5_run_pre", 32'(run_o), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("t5_async_run", 32'(run_o), 32'd0);
    check("t5_async_load", 32'(load_o), 32'd0);
    check("t5_async_tick", 32'(tick_o), 32'd0);
    check("t5_async_timeout", 32'(timeout_o), 32'd0);
    @(posedge clk);
    #1 RST = 1'b0;
    no_ticks("t5_after_rst", 6);
    check("t5_idle_run", 32'(run_o), 32'd0);
    check("t5_idle_load", 32'(load_o), 32'd0);
    check("t5_digits_kept", 32'(value()), 32'd9);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
